// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply, iterative radix-2 restoring divide.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops (reserved otherwise).
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             accept,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2((WIDTH > MUL_LAT ? WIDTH : MUL_LAT) + 1);

    typedef enum logic [3:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_e;

    state_e             r_state;
    logic               r_busy, r_div_zero;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_ma, r_mb;
    logic [WIDTH-1:0]   r_q, r_rem, r_dvs;
    logic               r_qneg, r_rneg, r_dz;

    logic               w_legal, w_is_mul, w_is_div, w_is_mthi, w_is_mtlo, w_signed;
    logic               w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_mul_a, w_mul_b, w_prod, w_hilo_new;
    logic [WIDTH:0]     w_rem_sh, w_diff;
    logic               w_fit;
    logic [WIDTH-1:0]   w_q_fix, w_r_fix;

`ifdef MULDIV_MADD_EN
    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;
    acc_e w_acc_mode, r_acc_mode, w_acc_sel;
`endif

    always_comb begin
        w_legal   = 1'b0;
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        w_is_mthi = 1'b0;
        w_is_mtlo = 1'b0;
        w_signed  = 1'b0;
`ifdef MULDIV_MADD_EN
        w_acc_mode = ACC_NONE;
`endif
        case (op_e'(op))
            OP_MULT:  begin w_legal = 1'b1; w_is_mul = 1'b1; w_signed = 1'b1; end
            OP_MULTU: begin w_legal = 1'b1; w_is_mul = 1'b1; end
            OP_DIV:   begin w_legal = 1'b1; w_is_div = 1'b1; w_signed = 1'b1; end
            OP_DIVU:  begin w_legal = 1'b1; w_is_div = 1'b1; end
            OP_MTHI:  begin w_legal = 1'b1; w_is_mthi = 1'b1; end
            OP_MTLO:  begin w_legal = 1'b1; w_is_mtlo = 1'b1; end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin w_legal = 1'b1; w_is_mul = 1'b1; w_signed = 1'b1; w_acc_mode = ACC_ADD; end
            OP_MADDU: begin w_legal = 1'b1; w_is_mul = 1'b1; w_acc_mode = ACC_ADD; end
            OP_MSUB:  begin w_legal = 1'b1; w_is_mul = 1'b1; w_signed = 1'b1; w_acc_mode = ACC_SUB; end
            OP_MSUBU: begin w_legal = 1'b1; w_is_mul = 1'b1; w_acc_mode = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    assign accept = op_valid & ~r_busy & ~flush & w_legal;

    assign w_ext_a = w_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    assign w_ext_b = w_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    assign w_neg_a = w_signed & src_a[WIDTH-1];
    assign w_neg_b = w_signed & src_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -src_a : src_a;
    assign w_mag_b = w_neg_b ? -src_b : src_b;

    // Single-cycle latency writes at the accept edge, so the multiplier then reads the ports directly
    assign w_mul_a = (MUL_LAT == 1) ? w_ext_a : r_ma;
    assign w_mul_b = (MUL_LAT == 1) ? w_ext_b : r_mb;
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef MULDIV_MADD_EN
    assign w_acc_sel = (MUL_LAT == 1) ? w_acc_mode : r_acc_mode;
    always_comb begin
        case (w_acc_sel)
            ACC_ADD: w_hilo_new = {r_hi, r_lo} + w_prod;
            ACC_SUB: w_hilo_new = {r_hi, r_lo} - w_prod;
            default: w_hilo_new = w_prod;
        endcase
    end
`else
    assign w_hilo_new = w_prod;
`endif

    assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_fit    = ~w_diff[WIDTH];
    assign w_q_fix  = r_qneg ? -r_q : r_q;
    assign w_r_fix  = r_rneg ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_dz       <= 1'b0;
`ifdef MULDIV_MADD_EN
            r_acc_mode <= ACC_NONE;
`endif
        end else begin
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: if (accept) begin
                    r_ma   <= w_ext_a;
                    r_mb   <= w_ext_b;
                    r_q    <= w_mag_a;
                    r_dvs  <= w_mag_b;
                    r_rem  <= '0;
                    r_qneg <= w_neg_a ^ w_neg_b;
                    r_rneg <= w_neg_a;
                    r_dz   <= (src_b == '0);
`ifdef MULDIV_MADD_EN
                    r_acc_mode <= w_acc_mode;
`endif
                    if (w_is_mthi) r_hi <= src_a;
                    if (w_is_mtlo) r_lo <= src_a;
                    if (w_is_mul) begin
                        if (MUL_LAT == 1) begin
                            {r_hi, r_lo} <= w_hilo_new;
                        end else begin
                            r_state <= S_MUL;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(MUL_LAT - 1);
                        end
                    end
                    if (w_is_div) begin
                        r_state <= S_DIV;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_hilo_new;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    r_rem <= w_fit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_fit};
                    if (r_cnt == '0) r_state <= S_DFIX;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                S_DFIX: begin
                    if (r_dz) begin
                        r_div_zero <= 1'b1;
                    end else begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule
